// File: rtl/keccak_pkg.sv
// Keccak input padder shared definitions: rate geometry, pad bytes, FSM states.
// Latency: n/a (constants, types and a helper function only).
// Backpressure: n/a.
// Build macro: KECCAK_PAD_SHA3_EN selects the SHA-3 domain byte 0x06; undefined gives Keccak 0x01.
package keccak_pkg;

   localparam int RATE_BYTES = 136;
   localparam int WORD_BYTES = 4;
   localparam int BLOCK_BITS = RATE_BYTES * 8;

`ifdef KECCAK_PAD_SHA3_EN
   localparam logic [7:0] PAD_DS = 8'h06;
`else
   localparam logic [7:0] PAD_DS = 8'h01;
`endif

   localparam logic [7:0] PAD_END = 8'h80;

   typedef enum logic [1:0] {
      FILL      = 2'd0,
      EMIT      = 2'd1,
      EMIT_LAST = 2'd2,
      DONE      = 2'd3
   } pad_state_e;

   // Bit offset of a block byte; block byte i lives at [8i+7:8i].
   function automatic logic [10:0] bit_ofs(input logic [7:0] byte_idx);
      return {byte_idx, 3'b000};
   endfunction

endpackage

// File: rtl/keccak_input_padder_if.sv
// Keccak input padder bus bundle: 32-bit word input stream and 1088-bit rate block output.
// Latency: n/a (wiring only).
// Backpressure: valid/ready on both the word side and the block side.
// Ports: in_valid/in_ready/in_data/in_nbytes/in_last (word in), out_valid/out_ready/out_block/out_last
// (block out), busy (message in progress). master = producer/consumer side, slave = padder.
interface keccak_input_padder_if;
   import keccak_pkg::*;

   logic                  in_valid;
   logic                  in_ready;
   logic [31:0]           in_data;
   logic [1:0]            in_nbytes;
   logic                  in_last;
   logic                  out_valid;
   logic                  out_ready;
   logic [BLOCK_BITS-1:0] out_block;
   logic                  out_last;
   logic                  busy;

   modport master (
      output in_valid, in_data, in_nbytes, in_last, out_ready,
      input  in_ready, out_valid, out_block, out_last, busy
   );

   modport slave (
      input  in_valid, in_data, in_nbytes, in_last, out_ready,
      output in_ready, out_valid, out_block, out_last, busy
   );

endinterface

// File: rtl/keccak_input_padder.sv
// Packs a 32-bit big-endian-in-word byte stream into 136-byte Keccak rate blocks and applies pad10*1.
// Latency: out_valid rises one cycle after the word that completes a block (or ends the message).
// Backpressure: in_ready drops while a block waits for out_ready; block held stable until accepted.
// Ports: S_AXI_ACLK clock, S_AXI_ARESETN async active-low reset, clr synchronous message restart,
//        pad_if (slave modport) carrying the word input stream, block output and busy flag.
// Build macro: KECCAK_PAD_SHA3_EN (domain byte 0x06 when defined, 0x01 otherwise; see keccak_pkg).
module keccak_input_padder
   import keccak_pkg::*;
(
   input  logic                  S_AXI_ACLK,
   input  logic                  S_AXI_ARESETN,
   input  logic                  clr,
   keccak_input_padder_if.slave  pad_if
);

   pad_state_e            state_q;
   logic [7:0]            ptr_q;
   logic [7:0]            ptr_d;
   logic [7:0]            pad_idx;
   logic [BLOCK_BITS-1:0] block_q;
   logic [BLOCK_BITS-1:0] block_d;
   logic                  out_valid_q;
   logic                  out_last_q;
   logic                  busy_q;

   assign ptr_d   = ptr_q + 8'(WORD_BYTES);
   assign pad_idx = ptr_q + {6'd0, pad_if.in_nbytes};

   // Byte-enable write of the current word into the block. A last word writes only its
   // in_nbytes leading bytes, then ORs the domain byte right after them and the end marker
   // into byte 135. ptr never exceeds 132 in FILL, so every write lands inside this block;
   // when ptr+in_nbytes is 135 the two pad bytes merge into one byte.
   always_comb begin
      block_d = block_q;
      for (int k = 0; k < WORD_BYTES; k++) begin
         if (!pad_if.in_last || (2'(k) < pad_if.in_nbytes)) begin
            block_d[bit_ofs(ptr_q + 8'(k)) +: 8] = pad_if.in_data[31-8*k -: 8];
         end
      end
      if (pad_if.in_last) begin
         block_d[bit_ofs(pad_idx) +: 8]  = block_d[bit_ofs(pad_idx) +: 8] | PAD_DS;
         block_d[BLOCK_BITS-8 +: 8]      = block_d[BLOCK_BITS-8 +: 8] | PAD_END;
      end
   end

   always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN) begin
         state_q     <= FILL;
         ptr_q       <= '0;
         block_q     <= '0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         busy_q      <= 1'b0;
      end else if (clr) begin
         // Restart wins over everything, including a word presented in the same cycle.
         state_q     <= FILL;
         ptr_q       <= '0;
         block_q     <= '0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         case (state_q)
            FILL: begin
               if (pad_if.in_valid) begin
                  block_q <= block_d;
                  busy_q  <= 1'b1;
                  if (pad_if.in_last) begin
                     state_q     <= EMIT_LAST;
                     out_valid_q <= 1'b1;
                     out_last_q  <= 1'b1;
                  end else begin
                     ptr_q <= ptr_d;
                     if (ptr_d == 8'(RATE_BYTES)) begin
                        state_q     <= EMIT;
                        out_valid_q <= 1'b1;
                     end
                  end
               end
            end
            EMIT: begin
               if (pad_if.out_ready) begin
                  state_q     <= FILL;
                  ptr_q       <= '0;
                  block_q     <= '0;
                  out_valid_q <= 1'b0;
               end
            end
            EMIT_LAST: begin
               if (pad_if.out_ready) begin
                  state_q     <= DONE;
                  out_valid_q <= 1'b0;
                  out_last_q  <= 1'b0;
                  busy_q      <= 1'b0;
               end
            end
            DONE: begin
               // Parked until the next clr starts a new message.
            end
            default: begin
               state_q <= FILL;
            end
         endcase
      end
   end

   assign pad_if.in_ready  = (state_q == FILL) && !clr;
   assign pad_if.out_valid = out_valid_q;
   assign pad_if.out_last  = out_last_q;
   assign pad_if.out_block = block_q;
   assign pad_if.busy      = busy_q;

endmodule

// File: tb/tb_keccak_input_padder.sv
// Testbench for keccak_input_padder: scoreboard of padded rate blocks built from each message.
// Latency: n/a.
// Backpressure: exercises held out_ready and random out_ready stalls.
module tb_keccak_input_padder;
   import keccak_pkg::*;

`ifdef KECCAK_PAD_SHA3_EN
   localparam logic [7:0] EXP_DS = 8'h06;
`else
   localparam logic [7:0] EXP_DS = 8'h01;
`endif
   localparam int RB = 136;

   typedef logic [7:0] bq_t[$];
   typedef struct {
      logic [1087:0] blk;
      logic          last;
   } exp_t;

   exp_t sb_q[$];
   int   passed = 0;
   int   total  = 0;
   bit   stall_done = 0;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic clr   = 1'b0;

   keccak_input_padder_if pif();

   keccak_input_padder dut (
      .S_AXI_ACLK    (clk),
      .S_AXI_ARESETN (rst_n),
      .clr           (clr),
      .pad_if        (pif)
   );

   always #5 clk = ~clk;

   // Scoreboard pop: every accepted block is compared with the oldest expected block.
   exp_t mon_e;
   int   mon_bad;
   always @(negedge clk) begin
      if (rst_n && pif.out_valid === 1'b1 && pif.out_ready === 1'b1) begin
         total++;
         if (sb_q.size() == 0) begin
            $display("FAIL unexpected_block got out_last=%b exp no block", pif.out_last);
         end else begin
            mon_e = sb_q.pop_front();
            if (pif.out_block !== mon_e.blk) begin
               mon_bad = -1;
               for (int i = 0; i < RB; i++) begin
                  if (pif.out_block[8*i +: 8] !== mon_e.blk[8*i +: 8]) begin
                     mon_bad = i;
                     break;
                  end
               end
               $display("FAIL block_data byte%0d got %h exp %h", mon_bad,
                        pif.out_block[8*mon_bad +: 8], mon_e.blk[8*mon_bad +: 8]);
            end else begin
               passed++;
            end
            total++;
            if (pif.out_last !== mon_e.last)
               $display("FAIL block_last got %b exp %b", pif.out_last, mon_e.last);
            else
               passed++;
         end
      end
   end

   // Reference padding: msg || DS || 0* with 0x80 ORed into the final byte of the final block.
   task automatic push_expected(input bq_t msg);
      bq_t  padded;
      int   nblk;
      exp_t e;
      nblk   = (msg.size() + RB) / RB;
      padded = msg;
      padded.push_back(EXP_DS);
      while (padded.size() < nblk * RB) padded.push_back(8'h00);
      padded[nblk*RB-1] = padded[nblk*RB-1] | 8'h80;
      for (int b = 0; b < nblk; b++) begin
         e.blk = '0;
         for (int i = 0; i < RB; i++) e.blk[8*i +: 8] = padded[b*RB+i];
         e.last = (b == nblk - 1);
         sb_q.push_back(e);
      end
   endtask

   // Called at a negedge; returns at the negedge after the word is accepted.
   task automatic send_word(input logic [31:0] d, input logic [1:0] nb, input logic last);
      int cnt;
      pif.in_valid  = 1'b1;
      pif.in_data   = d;
      pif.in_nbytes = nb;
      pif.in_last   = last;
      cnt = 0;
      while (pif.in_ready !== 1'b1 && cnt < 500) begin
         @(negedge clk);
         cnt++;
      end
      total++;
      if (cnt >= 500) $display("FAIL send_timeout got in_ready=%b exp 1", pif.in_ready);
      else passed++;
      @(negedge clk);
      pif.in_valid  = 1'b0;
      pif.in_last   = 1'b0;
      pif.in_nbytes = 2'd0;
   endtask

   task automatic send_msg(input bq_t msg, input logic [7:0] garbage);
      int          nfull;
      int          rem;
      logic [31:0] d;
      nfull = msg.size() / 4;
      rem   = msg.size() % 4;
      for (int w = 0; w < nfull; w++)
         send_word({msg[4*w], msg[4*w+1], msg[4*w+2], msg[4*w+3]}, 2'd0, 1'b0);
      d = {4{garbage}};
      for (int k = 0; k < rem; k++) d[31-8*k -: 8] = msg[4*nfull+k];
      send_word(d, 2'(rem), 1'b1);
   endtask

   task automatic clr_pulse();
      @(negedge clk);
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      #1;
   endtask

   task automatic wait_drain(output bit ok);
      int cnt;
      cnt = 0;
      while ((sb_q.size() != 0 || pif.out_valid === 1'b1) && cnt < 3000) begin
         @(negedge clk);
         cnt++;
      end
      ok = (cnt < 3000);
   endtask

   task automatic test_reset();
      pif.in_valid  = 1'b0;
      pif.in_data   = '0;
      pif.in_nbytes = 2'd0;
      pif.in_last   = 1'b0;
      pif.out_ready = 1'b1;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      #1;
      total++;
      if ({pif.out_valid, pif.out_last, pif.busy} !== 3'b000)
         $display("FAIL reset_flags got v/l/b=%b%b%b exp 000", pif.out_valid, pif.out_last, pif.busy);
      else passed++;
      total++;
      if (pif.in_ready !== 1'b1) $display("FAIL reset_in_ready got %b exp 1", pif.in_ready);
      else passed++;
      total++;
      if (pif.out_block !== '0) $display("FAIL reset_block got nonzero exp zero");
      else passed++;
      // Reset must act without a clock edge.
      @(negedge clk);
      send_word(32'h01020304, 2'd0, 1'b0);
      send_word(32'h05060708, 2'd0, 1'b0);
      rst_n = 1'b0;
      #1;
      total++;
      if (pif.busy !== 1'b0) $display("FAIL async_reset_busy got %b exp 0", pif.busy);
      else passed++;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_empty();
      bq_t msg;
      bit  ok;
      clr_pulse();
      @(negedge clk);
      push_expected(msg);
      send_word(32'h00AABBCC, 2'd0, 1'b1);
      total++;
      if ({pif.out_valid, pif.out_last, pif.busy} !== 3'b111)
         $display("FAIL empty_latency got v/l/b=%b%b%b exp 111", pif.out_valid, pif.out_last, pif.busy);
      else passed++;
      @(negedge clk);
      total++;
      if ({pif.out_valid, pif.busy, pif.in_ready} !== 3'b000)
         $display("FAIL empty_done got v/b/rdy=%b%b%b exp 000", pif.out_valid, pif.busy, pif.in_ready);
      else passed++;
      wait_drain(ok);
      total++;
      if (!ok) $display("FAIL empty_drain got %0d pending exp 0", sb_q.size());
      else passed++;
   endtask

   task automatic test_hello();
      bq_t   msg;
      string s;
      bit    ok;
      s = "Hello World";
      for (int i = 0; i < s.len(); i++) msg.push_back(s[i]);
      clr_pulse();
      @(negedge clk);
      push_expected(msg);
      send_msg(msg, 8'h20);
      wait_drain(ok);
      total++;
      if (!ok) $display("FAIL hello_drain got %0d pending exp 0", sb_q.size());
      else passed++;
   endtask

   task automatic test_multi_block_stall();
      bq_t           msg;
      logic [1087:0] first_blk;
      bit            ok;
      for (int i = 0; i < RB; i++) begin
         msg.push_back((i % 4 == 3) ? 8'h31 : 8'h30);
         first_blk[8*i +: 8] = (i % 4 == 3) ? 8'h31 : 8'h30;
      end
      clr_pulse();
      @(negedge clk);
      pif.out_ready = 1'b0;
      push_expected(msg);
      for (int w = 0; w < 34; w++) send_word(32'h30303031, 2'd0, 1'b0);
      for (int c = 0; c < 5; c++) begin
         total++;
         if ({pif.out_valid, pif.out_last} !== 2'b10)
            $display("FAIL stall_flags c%0d got v/l=%b%b exp 10", c, pif.out_valid, pif.out_last);
         else passed++;
         total++;
         if (pif.out_block !== first_blk) $display("FAIL stall_block c%0d got changed exp held", c);
         else passed++;
         total++;
         if (pif.in_ready !== 1'b0) $display("FAIL stall_in_ready c%0d got %b exp 0", c, pif.in_ready);
         else passed++;
         @(negedge clk);
      end
      @(posedge clk);
      #1 pif.out_ready = 1'b1;
      @(negedge clk);
      send_word(32'hAABBCCDD, 2'd0, 1'b1);
      wait_drain(ok);
      total++;
      if (!ok) $display("FAIL stall_drain got %0d pending exp 0", sb_q.size());
      else passed++;
   endtask

   task automatic test_pad_overlap();
      bq_t msg;
      bit  ok;
      for (int i = 0; i < 135; i++) msg.push_back(8'($urandom_range(0, 255)));
      clr_pulse();
      @(negedge clk);
      push_expected(msg);
      send_msg(msg, 8'h5A);
      wait_drain(ok);
      total++;
      if (!ok) $display("FAIL overlap_drain got %0d pending exp 0", sb_q.size());
      else passed++;
      repeat (3) @(negedge clk);
      total++;
      if (pif.out_valid !== 1'b0) $display("FAIL overlap_extra_block got %b exp 0", pif.out_valid);
      else passed++;
   endtask

   task automatic test_clr_abort();
      bq_t msg;
      bit  ok;
      clr_pulse();
      @(negedge clk);
      for (int w = 0; w < 10; w++) begin
         send_word($urandom, 2'd0, 1'b0);
         total++;
         if (pif.out_valid !== 1'b0) $display("FAIL abort_no_valid w%0d got %b exp 0", w, pif.out_valid);
         else passed++;
      end
      total++;
      if (pif.busy !== 1'b1) $display("FAIL abort_busy got %b exp 1", pif.busy);
      else passed++;
      // Word presented together with clr must be dropped.
      clr           = 1'b1;
      pif.in_valid  = 1'b1;
      pif.in_data   = 32'h11223344;
      pif.in_last   = 1'b0;
      #1;
      total++;
      if (pif.in_ready !== 1'b0) $display("FAIL abort_ready_in_clr got %b exp 0", pif.in_ready);
      else passed++;
      @(negedge clk);
      clr          = 1'b0;
      pif.in_valid = 1'b0;
      #1;
      total++;
      if ({pif.busy, pif.out_valid, pif.in_ready} !== 3'b001)
         $display("FAIL abort_after_clr got b/v/rdy=%b%b%b exp 001", pif.busy, pif.out_valid, pif.in_ready);
      else passed++;
      @(negedge clk);
      push_expected(msg);
      send_word(32'h00AABBCC, 2'd0, 1'b1);
      wait_drain(ok);
      total++;
      if (!ok) $display("FAIL abort_drain got %0d pending exp 0", sb_q.size());
      else passed++;
   endtask

   task automatic test_back_to_back();
      int lens[4] = '{140, 271, 7, 0};
      stall_done = 0;
      fork
         begin
            bq_t msg;
            bit  ok;
            for (int m = 0; m < 4; m++) begin
               msg = {};
               for (int i = 0; i < lens[m]; i++) msg.push_back(8'($urandom_range(0, 255)));
               clr_pulse();
               @(negedge clk);
               push_expected(msg);
               send_msg(msg, 8'hC3);
               wait_drain(ok);
               total++;
               if (!ok) $display("FAIL b2b_drain m%0d got %0d pending exp 0", m, sb_q.size());
               else passed++;
            end
            stall_done = 1;
         end
         begin
            while (!stall_done) begin
               @(posedge clk);
               #1 pif.out_ready = 1'($urandom_range(0, 1));
            end
            pif.out_ready = 1'b1;
         end
      join
   endtask

   initial begin
      test_reset();
      test_empty();
      test_hello();
      test_multi_block_stall();
      test_pad_overlap();
      test_clr_abort();
      test_back_to_back();
      repeat (2) @(negedge clk);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/keccak_input_padder.md
KECCAK_INPUT_PADDER -- requirements
Module: keccak_input_padder

Interface
REQ-001 Clock and reset SHALL be one clock and an asynchronous, active-low reset, named as in the codebase's AXI peripheral.
REQ-002 S_AXI_ACLK  in  1  sole clock; all state updates on rising edge.
REQ-003 S_AXI_ARESETN  in  1  asynchronous active-low reset.
REQ-004 clr  in  1  synchronous message restart (COMMAND bit 0).
REQ-005 in_valid  in  1  input word valid.
REQ-006 in_ready  out  1  word accepted when in_valid && in_ready.
REQ-007 in_data  in  32  message bytes; first byte in [31:24], fourth byte in [7:0].
REQ-008 in_nbytes  in  2  valid bytes when in_last=1 (0..3); ignored when in_last=0, which means 4 bytes.
REQ-009 in_last  in  1  word ends message.
REQ-010 out_valid  out  1  rate block available.
REQ-011 out_ready  in  1  consumer (permutation core) accepts block.
REQ-012 out_block  out  1088  block; block byte i at [8i+7:8i].
REQ-013 out_last  out  1  block is final, padded block.
REQ-014 busy  out  1  high from first accepted word until final block handshake.

Function
REQ-015 States SHALL be FILL, EMIT, EMIT_LAST, DONE.
REQ-016 Transitions:
- FILL -> EMIT when a non-last word brings the pointer to 136.
- FILL -> EMIT_LAST on an accepted last word.
- EMIT -> FILL on out_ready.
- EMIT_LAST -> DONE on out_ready.
- DONE -> FILL only on clr.
REQ-017 in_ready SHALL equal (state==FILL && !clr).
REQ-018 The byte pointer ptr (0..136, 8 bits) SHALL advance by 4 per non-last word; word bytes SHALL be written at ptr..ptr+3.
REQ-019 On a last word, the block SHALL receive in_nbytes bytes at ptr.., then pad byte PAD_DS OR-ed at ptr+in_nbytes, then 0x80 OR-ed at byte 135.
REQ-020 The 0x01 and 0x80 pad bytes coincide at 135 when ptr+in_nbytes=135, giving 0x81.
REQ-021 Padding SHALL always fit the current block, because ptr<=132 and in_nbytes<=3; no extra pad-only block is ever generated.
REQ-022 Unwritten block bytes SHALL be zero; the block register SHALL be zeroed and ptr set to 0 on each EMIT->FILL.
REQ-023 out_valid SHALL rise the cycle after the completing word is accepted (1-cycle latency).
REQ-024 out_block and out_last SHALL be held stable while out_valid && !out_ready.
REQ-025 out_valid SHALL equal (state==EMIT || state==EMIT_LAST); out_last SHALL equal (state==EMIT_LAST).
REQ-026 clr SHALL take priority in any state: state FILL, ptr 0, block zeroed, out_valid low next cycle, busy low; a coincident input word is dropped.

Reset
REQ-027 On S_AXI_ARESETN low: state FILL, ptr 0, block all-zero, out_valid 0, out_last 0, busy 0, in_ready 1 after release.

Configuration
REQ-028 With KECCAK_PAD_SHA3_EN defined, PAD_DS SHALL be 0x06 (FIPS-202 SHA-3); undefined, PAD_DS SHALL be 0x01 (original Keccak).

Structure
REQ-029 Package keccak_pkg SHALL hold:
- RATE_BYTES=136
- WORD_BYTES=4
- PAD_DS
- PAD_END=0x80
- the state enum
REQ-030 No sub-module; single module with one FSM and a byte-enable write into the block register.

Verification
REQ-031 Empty message: clr, then last word with nbytes=0 and data 0x00AABBCC -> one block with byte0=0x01, byte135=0x80, all other bytes 0, out_last=1.
REQ-032 "Hello World": "Hell", "o Wo", then last "rld " with nbytes=3 -> bytes 0..10 = 48 65 6C 6C 6F 20 57 6F 72 6C 64, byte11=0x01, byte135=0x80.
REQ-033 34 words "0001", then last nbytes=0, out_ready held low 5 cycles -> first block = "0001" repeated with out_last=0, stable for all 5 cycles, in_ready=0 meanwhile; second block byte0=0x01, byte135=0x80, out_last=1.
REQ-034 33 full words, then last nbytes=3 -> byte135=0x81, single block.
REQ-035 clr after 10 words, then empty message -> no out_valid before clr; result identical to REQ-031.
REQ-036 KECCAK_PAD_SHA3_EN defined, empty message -> byte0=0x06, byte135=0x80.
